add8_share_arbiter: RTL and testbench

ADD8_SHARE_ARBITER -- requirements
Module: add8_share_arbiter

---
 rtl/add8_share_pkg.sv | 13 +
 rtl/add8_share_arbiter_core.sv | 14 +
 rtl/add8_share_arbiter.sv | 132 +++++++++++++
 tb/tb_add8_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add8_share_pkg.sv
// Shared defaults and state encoding for the add8 sharing arbiter.
package add8_share_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 8;
   localparam int CW_DEF   = 16;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage : add8_share_pkg

// File: rtl/add8_share_arbiter_core.sv
// Combinational W-bit adder; replace the body with an approximate netlist as needed.
module add8_core
   import add8_share_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W:0]   sum_o
);

   assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : add8_core

// File: rtl/add8_share_arbiter.sv
// Round-robin arbiter sharing one add8_core among NREQ requesters, with a
// single-entry result register that sustains one result per cycle.
module add8_share_arbiter
   import add8_share_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*W-1:0]        req_a,
   input  logic [NREQ*W-1:0]        req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     res_valid,
   output logic [W:0]               res_sum,
   output logic [$clog2(NREQ)-1:0]  res_id,
   input  logic                     res_ready,
   output logic [CW-1:0]            op_count
);

   localparam int IDW = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [W:0]       res_sum_q, res_sum_d;
   logic [IDW-1:0]   res_id_q, res_id_d;
   logic [CW-1:0]    op_count_q, op_count_d;

   logic             can_accept_s;
   logic             found_s;
   logic             xfer_s;
   logic [IDW-1:0]   gidx_s;
   logic [IDW:0]     cand_s;
   logic [NREQ-1:0]  grant_s;
   logic [W-1:0]     op_a_s;
   logic [W-1:0]     op_b_s;
   logic [W:0]       core_sum_s;

   // Search upward from rr_ptr for the first valid requester, wrapping at NREQ.
   always_comb begin
      found_s = 1'b0;
      gidx_s  = '0;
      cand_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand_s >= (IDW+1)'(NREQ)) begin
            cand_s = cand_s - (IDW+1)'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_valid[cand_s[IDW-1:0]]) begin
            found_s = 1'b1;
            gidx_s  = cand_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign can_accept_s = (state_q == EMPTY) || res_ready;

   // Grant is suppressed during reset so nothing can transfer while rst_n is low.
   always_comb begin
      grant_s = '0;
      if (rst_n && can_accept_s && found_s) begin
         grant_s[gidx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   assign req_ready = grant_s;
   assign xfer_s    = |grant_s;

   assign op_a_s = req_a[int'(gidx_s)*W +: W];
   assign op_b_s = req_b[int'(gidx_s)*W +: W];

   add8_core #(.W(W)) u_core (
      .a_i   (op_a_s),
      .b_i   (op_b_s),
      .sum_o (core_sum_s)
   );

   // Next-state: a transfer always refills the result register, else a consumed result empties it.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      res_sum_d  = res_sum_q;
      res_id_d   = res_id_q;
      op_count_d = op_count_q;
      if (xfer_s) begin
         state_d   = FULL;
         rr_ptr_d  = (gidx_s == IDW'(NREQ-1)) ? '0 : gidx_s + IDW'(1);
         res_sum_d = core_sum_s;
         res_id_d  = gidx_s;
         if (op_count_q != {CW{1'b1}}) begin
            op_count_d = op_count_q + CW'(1);
         end else begin
            op_count_d = op_count_q;
         end
      end else if (res_ready) begin
         state_d = EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         rr_ptr_q   <= '0;
         res_sum_q  <= '0;
         res_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         res_sum_q  <= res_sum_d;
         res_id_q   <= res_id_d;
         op_count_q <= op_count_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_sum   = res_sum_q;
   assign res_id    = res_id_q;
   assign op_count  = op_count_q;

endmodule : add8_share_arbiter

// File: tb/tb_add8_share_arbiter.sv
// Scoreboard bench for add8_share_arbiter: a free-running reference monitor plus directed scenario tasks.
module tb_add8_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = 4'b0000;
   logic [31:0] req_a = 32'h0;
   logic [31:0] req_b = 32'h0;
   logic        res_ready = 1'b0;

   logic [3:0]  req_ready;
   logic        res_valid;
   logic [8:0]  res_sum;
   logic [1:0]  res_id;
   logic [15:0] op_count;

   logic [3:0]  sat_req_ready;
   logic        sat_res_valid;
   logic [8:0]  sat_res_sum;
   logic [1:0]  sat_res_id;
   logic [3:0]  sat_op_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   add8_share_arbiter #(.NREQ(NREQ), .W(W), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id),
      .res_ready(res_ready), .op_count(op_count)
   );

   add8_share_arbiter #(.NREQ(NREQ), .W(W), .CW(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(sat_req_ready), .res_valid(sat_res_valid), .res_sum(sat_res_sum), .res_id(sat_res_id),
      .res_ready(res_ready), .op_count(sat_op_count)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [8:0] sum;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur_m = '0;
   exp_t        popped;
   logic [3:0]  exp_g;
   int          rr_m = 0;
   int          gi_m = 0;
   int          c_m = 0;
   bit          full_m = 1'b0;
   bit          xfer_m = 1'b0;
   bit          rst_pre = 1'b0;
   bit          rdy_pre = 1'b0;
   int          cnt_m = 0;
   int          cnt_sat_m = 0;
   int          trans_m[4];
   int          cons_m[4];

   // Reference model: predicts grants pre-edge, pushes expected sums, pops and compares post-edge.
   initial begin : monitor
      for (int i = 0; i < 4; i++) begin
         trans_m[i] = 0;
         cons_m[i]  = 0;
      end
      forever begin
         @(negedge clk);
         #2;
         exp_g = 4'b0000;
         gi_m  = 0;
         if (rst_n && (!full_m || res_ready)) begin
            for (int k = 0; k < 4; k++) begin
               c_m = (rr_m + k) % 4;
               if (exp_g == 4'b0000 && req_valid[c_m]) begin
                  exp_g[c_m] = 1'b1;
                  gi_m = c_m;
               end
            end
         end
         n_checks++;
         if (req_ready !== exp_g) begin
            n_fail++;
            $display("FAIL sb_grant: got %b expected %b at %0t", req_ready, exp_g, $time);
         end
         n_checks++;
         if (sat_req_ready !== exp_g) begin
            n_fail++;
            $display("FAIL sb_grant_sat: got %b expected %b at %0t", sat_req_ready, exp_g, $time);
         end
         xfer_m = (exp_g != 4'b0000);
         if (xfer_m) begin
            exp_q.push_back({2'(gi_m), 9'({1'b0, req_a[gi_m*8 +: 8]} + {1'b0, req_b[gi_m*8 +: 8]})});
            trans_m[gi_m]++;
         end
         if (rst_n && res_valid && res_ready) cons_m[res_id]++;
         rst_pre = rst_n;
         rdy_pre = res_ready;
         @(posedge clk);
         #1;
         if (!rst_pre) begin
            full_m = 1'b0;
            rr_m = 0;
            cnt_m = 0;
            cnt_sat_m = 0;
            cur_m = '0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
               trans_m[i] = 0;
               cons_m[i]  = 0;
            end
         end else if (xfer_m) begin
            popped = exp_q.pop_front();
            cur_m = popped;
            full_m = 1'b1;
            rr_m = (gi_m + 1) % 4;
            if (cnt_m != 65535) cnt_m++;
            if (cnt_sat_m != 15) cnt_sat_m++;
         end else if (rdy_pre) begin
            full_m = 1'b0;
         end
         n_checks++;
         if (res_valid !== full_m || sat_res_valid !== full_m) begin
            n_fail++;
            $display("FAIL sb_valid: got %b/%b expected %b at %0t", res_valid, sat_res_valid, full_m, $time);
         end
         n_checks++;
         if (res_sum !== cur_m.sum || res_id !== cur_m.id || sat_res_sum !== cur_m.sum) begin
            n_fail++;
            $display("FAIL sb_result: got sum %h id %0d expected sum %h id %0d at %0t",
                     res_sum, res_id, cur_m.sum, cur_m.id, $time);
         end
         n_checks++;
         if (op_count !== 16'(cnt_m) || sat_op_count !== 4'(cnt_sat_m)) begin
            n_fail++;
            $display("FAIL sb_count: got %0d/%0d expected %0d/%0d at %0t",
                     op_count, sat_op_count, cnt_m, cnt_sat_m, $time);
         end
      end
   end

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1;
         req_a = $urandom(); req_b = $urandom();
         #2;
         n_checks++;
         if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (res_valid !== 1'b0 || op_count !== 16'd0 || res_sum !== 9'd0 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid %b cnt %0d sum %h id %0d expected 0 0 0 0",
                     res_valid, op_count, res_sum, res_id);
         end
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      rst_n = 1'b1; req_valid = 4'b0001; res_ready = 1'b1;
      req_a = 32'hA5C3_7710; req_b = 32'h1E2F_3C20;
      #2;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 0001", req_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== 9'h030 || res_id !== 2'd0 || op_count !== 16'd1) begin
         n_fail++;
         $display("FAIL single_result: got valid %b sum %h id %0d cnt %0d expected 1 030 0 1",
                  res_valid, res_sum, res_id, op_count);
      end
   endtask

   task automatic test_round_robin();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 4'h0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rst_n = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
         req_a = $urandom(); req_b = $urandom();
         #2;
         n_checks++;
         if (req_ready !== 4'(1 << (k % 4))) begin
            n_fail++;
            $display("FAIL rr_grant: step %0d got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (res_valid !== 1'b1 || res_id !== 2'(k % 4)) begin
            n_fail++;
            $display("FAIL rr_result: step %0d got valid %b id %0d expected 1 %0d", k, res_valid, res_id, k % 4);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] held_sum;
      logic [1:0] held_id;
      logic [8:0] exp_sum;
      held_sum = res_sum;
      held_id  = res_id;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 4'hF; res_ready = 1'b0;
         req_a = $urandom(); req_b = $urandom();
         #2;
         n_checks++;
         if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready: step %0d got %b expected 0000", k, req_ready);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (res_valid !== 1'b1 || res_sum !== held_sum || res_id !== held_id) begin
            n_fail++;
            $display("FAIL bp_hold: got valid %b sum %h id %0d expected 1 %h %0d",
                     res_valid, res_sum, res_id, held_sum, held_id);
         end
      end
      @(negedge clk);
      res_ready = 1'b1;
      req_a = $urandom(); req_b = $urandom();
      exp_sum = {1'b0, req_a[15:8]} + {1'b0, req_b[15:8]};
      #2;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== exp_sum) begin
         n_fail++;
         $display("FAIL bp_replace: got valid %b id %0d sum %h expected 1 1 %h", res_valid, res_id, res_sum, exp_sum);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 4'b0100; res_ready = 1'b1;
      req_a = $urandom(); req_b = $urandom();
      @(posedge clk);
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_setup: got valid %b id %0d expected 1 2", res_valid, res_id);
      end
      @(negedge clk);
      rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b0;
      #2;
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_ready: got %b expected 0000", req_ready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || op_count !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_cleared: got valid %b cnt %0d expected 0 0", res_valid, op_count);
      end
      @(negedge clk);
      rst_n = 1'b1; res_ready = 1'b1;
      #2;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         rst_n = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
         req_a = $urandom(); req_b = $urandom();
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (sat_op_count !== 4'd15 || op_count !== 16'd20) begin
         n_fail++;
         $display("FAIL sat_count: got %0d/%0d expected 15/20", sat_op_count, op_count);
      end
   endtask

   task automatic test_random();
      int pending;
      for (int k = 0; k < 10000; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         req_valid = 4'($urandom_range(0, 15));
         res_ready = ($urandom_range(0, 3) != 0);
         req_a = $urandom(); req_b = $urandom();
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 4; i++) begin
         pending = (full_m && cur_m.id == 2'(i)) ? 1 : 0;
         n_checks++;
         if (trans_m[i] == 0 || trans_m[i] !== cons_m[i] + pending) begin
            n_fail++;
            $display("FAIL rand_conservation: req %0d got %0d consumed + %0d pending expected %0d accepted",
                     i, cons_m[i], pending, trans_m[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_add8_share_arbiter
